// File: rtl/block_nest_checker_pkg.sv
// Shared types and constants for the begin/end nesting checker.
// The keyword-recognition transition function lives here so it can be reused and unit-tested on its own.
package block_nest_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_B     = 4'd1,
    ST_BE    = 4'd2,
    ST_BEG   = 4'd3,
    ST_BEGI  = 4'd4,
    ST_BEGIN = 4'd5,
    ST_E     = 4'd6,
    ST_EN    = 4'd7,
    ST_END   = 4'd8,
    ST_WORD  = 4'd9
  } state_t;

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_B     = 8'h62;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_G     = 8'h67;
  localparam logic [7:0] CH_I     = 8'h69;
  localparam logic [7:0] CH_N     = 8'h6e;
  localparam logic [7:0] CH_D     = 8'h64;

  // Next state for a lower-cased letter; any letter that breaks a keyword falls into WORD.
  function automatic state_t next_alpha(input state_t cur, input logic [7:0] lc);
    state_t nxt;
    nxt = ST_WORD;
    case (cur)
      ST_IDLE: begin
        if (lc == CH_B) begin
          nxt = ST_B;
        end else if (lc == CH_E) begin
          nxt = ST_E;
        end else begin
          nxt = ST_WORD;
        end
      end
      ST_B:    nxt = (lc == CH_E) ? ST_BE   : ST_WORD;
      ST_BE:   nxt = (lc == CH_G) ? ST_BEG  : ST_WORD;
      ST_BEG:  nxt = (lc == CH_I) ? ST_BEGI : ST_WORD;
      ST_BEGI: nxt = (lc == CH_N) ? ST_BEGIN : ST_WORD;
      ST_E:    nxt = (lc == CH_N) ? ST_EN   : ST_WORD;
      ST_EN:   nxt = (lc == CH_D) ? ST_END  : ST_WORD;
      default: nxt = ST_WORD;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/block_nest_checker_classifier.sv
// Combinational character classifier: space / letter detection and lower-case folding.
module ascii_classifier
  import block_nest_pkg::*;
(
  input  logic [7:0] in,
  output logic       is_space,
  output logic       is_alpha,
  output logic [7:0] lc
);

  logic is_upper_s;
  logic is_lower_s;

  // Classify the incoming byte and fold upper case onto lower case.
  always_comb begin
    is_space   = (in == CH_SPACE);
    is_upper_s = (in >= 8'h41) && (in <= 8'h5a);
    is_lower_s = (in >= 8'h61) && (in <= 8'h7a);
    is_alpha   = is_upper_s | is_lower_s;
    if (is_upper_s) begin
      lc = in | 8'h20;
    end else begin
      lc = in;
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end nesting checker: keyword FSM, saturating depth counter,
// overflow/underflow flags and a registered "balanced so far" result.
module block_nest_checker
  import block_nest_pkg::*;
#(
  parameter int DEPTH_W    = 8,
  parameter bit STICKY_ERR = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in,
  input  logic               in_valid,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam logic [DEPTH_W-1:0] DEPTH_ZERO = {DEPTH_W{1'b0}};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE  = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX  = {DEPTH_W{1'b1}};

  logic               is_space_s;
  logic               is_alpha_s;
  logic [7:0]         lc_s;

  state_t             state_r;
  state_t             state_nx_s;
  logic [DEPTH_W-1:0] depth_nx_s;
  logic               ovf_nx_s;
  logic               unf_nx_s;
  logic               balanced_s;
  logic               result_nx_s;

  ascii_classifier u_classifier (
    .in       (in),
    .is_space (is_space_s),
    .is_alpha (is_alpha_s),
    .lc       (lc_s)
  );

  // Next-state, depth and flag computation for an accepted character.
  always_comb begin
    state_nx_s = state_r;
    depth_nx_s = depth;
    ovf_nx_s   = err_overflow;
    unf_nx_s   = err_underflow;
    if (is_space_s) begin
      state_nx_s = ST_IDLE;
      case (state_r)
        ST_BEGIN: begin
          if (depth == DEPTH_MAX) begin
            ovf_nx_s = 1'b1;
          end else begin
            depth_nx_s = depth + DEPTH_ONE;
          end
        end
        ST_END: begin
          if (depth == DEPTH_ZERO) begin
            unf_nx_s = 1'b1;
          end else begin
            depth_nx_s = depth - DEPTH_ONE;
            // Non-sticky mode: returning to an empty nest forgives earlier errors.
            if (!STICKY_ERR && (depth == DEPTH_ONE)) begin
              ovf_nx_s = 1'b0;
              unf_nx_s = 1'b0;
            end else begin
              ovf_nx_s = err_overflow;
              unf_nx_s = err_underflow;
            end
          end
        end
        default: begin
          depth_nx_s = depth;
        end
      endcase
    end else if (is_alpha_s) begin
      state_nx_s = next_alpha(state_r, lc_s);
    end else begin
      state_nx_s = ST_WORD;
    end
  end

  // Balanced check treats an unterminated keyword as if it had already been committed.
  always_comb begin
    case (state_nx_s)
      ST_BEGIN: balanced_s = 1'b0;
      ST_END:   balanced_s = (depth_nx_s == DEPTH_ONE);
      default:  balanced_s = (depth_nx_s == DEPTH_ZERO);
    endcase
    result_nx_s = !(ovf_nx_s | unf_nx_s) & balanced_s;
  end

  // State and output registers; everything holds while no character is offered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      depth         <= DEPTH_ZERO;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      result        <= 1'b1;
    end else if (in_valid) begin
      state_r       <= state_nx_s;
      depth         <= depth_nx_s;
      err_overflow  <= ovf_nx_s;
      err_underflow <= unf_nx_s;
      result        <= result_nx_s;
    end else begin
      state_r       <= state_r;
      depth         <= depth;
      err_overflow  <= err_overflow;
      err_underflow <= err_underflow;
      result        <= result;
    end
  end

endmodule

// File: tb/tb_block_nest_checker.sv
// Scoreboard bench for block_nest_checker: two instances (default and DEPTH_W=2/non-sticky)
// checked against a string-based reference model of the word stream.
module tb_block_nest_checker;

  typedef struct packed {
    logic       r;
    logic [7:0] d;
    logic       o;
    logic       u;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic       in_valid;

  logic       result_a, err_overflow_a, err_underflow_a;
  logic [7:0] depth_a;
  logic       result_b, err_overflow_b, err_underflow_b;
  logic [1:0] depth_b;

  int checks = 0;
  int fails  = 0;

  obs_t exp_a[$];
  obs_t act_a[$];
  obs_t exp_b[$];
  obs_t act_b[$];

  int    m_depth[2];
  int    m_max[2];
  bit    m_sticky[2];
  bit    m_ovf[2];
  bit    m_unf[2];
  string m_word[2];

  block_nest_checker u_dut_a (
    .clk           (clk),
    .reset         (reset),
    .in            (in),
    .in_valid      (in_valid),
    .result        (result_a),
    .depth         (depth_a),
    .err_overflow  (err_overflow_a),
    .err_underflow (err_underflow_a)
  );

  block_nest_checker #(.DEPTH_W(2), .STICKY_ERR(1'b0)) u_dut_b (
    .clk           (clk),
    .reset         (reset),
    .in            (in),
    .in_valid      (in_valid),
    .result        (result_b),
    .depth         (depth_b),
    .err_overflow  (err_overflow_b),
    .err_underflow (err_underflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_depth[k] = 0;
      m_ovf[k]   = 1'b0;
      m_unf[k]   = 1'b0;
      m_word[k]  = "";
    end
  endtask

  task automatic model_step(input int k, input logic [7:0] c);
    string lw;
    if (c == 8'h20) begin
      lw = m_word[k].tolower();
      if (lw == "begin") begin
        if (m_depth[k] == m_max[k]) m_ovf[k] = 1'b1;
        else m_depth[k] = m_depth[k] + 1;
      end else if (lw == "end") begin
        if (m_depth[k] == 0) begin
          m_unf[k] = 1'b1;
        end else begin
          m_depth[k] = m_depth[k] - 1;
          if (m_depth[k] == 0 && !m_sticky[k]) begin
            m_ovf[k] = 1'b0;
            m_unf[k] = 1'b0;
          end
        end
      end
      m_word[k] = "";
    end else begin
      m_word[k] = $sformatf("%s%c", m_word[k], c);
    end
  endtask

  function automatic obs_t model_obs(input int k);
    string lw;
    logic  bal;
    obs_t  o;
    lw = m_word[k].tolower();
    if (lw == "begin") bal = 1'b0;
    else if (lw == "end") bal = (m_depth[k] == 1);
    else bal = (m_depth[k] == 0);
    o.r = !(m_ovf[k] || m_unf[k]) && bal;
    o.d = 8'(m_depth[k]);
    o.o = m_ovf[k];
    o.u = m_unf[k];
    return o;
  endfunction

  task automatic sample_outputs();
    act_a.push_back({result_a, depth_a, err_overflow_a, err_underflow_a});
    act_b.push_back({result_b, 6'd0, depth_b, err_overflow_b, err_underflow_b});
  endtask

  task automatic drive_char(input logic [7:0] c, input bit v);
    in       = c;
    in_valid = v;
    if (v) begin
      model_step(0, c);
      model_step(1, c);
    end
    exp_a.push_back(model_obs(0));
    exp_b.push_back(model_obs(1));
    @(posedge clk);
    #1;
    sample_outputs();
    in_valid = 1'b0;
  endtask

  task automatic drive_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      drive_char(s[i], 1'b1);
      if (gaps) drive_char(8'($urandom_range(32'h21, 32'h7e)), 1'b0);
    end
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    in       = 8'h62;
    in_valid = 1'b1;
    model_reset();
    exp_a.push_back(model_obs(0));
    exp_b.push_back(model_obs(1));
    @(posedge clk);
    #1;
    sample_outputs();
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    obs_t ea, aa, eb, ab;
    apply_reset();
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL reset_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL reset_b actual=%h expected=%h", ab, eb); end
    end
    checks++;
    if ({result_a, depth_a, err_overflow_a, err_underflow_a} !== 11'b1_00000000_0_0) begin
      fails++;
      $display("FAIL reset_values actual=%b%h%b%b expected r=1 d=0 o=0 u=0",
               result_a, depth_a, err_overflow_a, err_underflow_a);
    end
  endtask

  task automatic test_basic();
    obs_t ea, aa, eb, ab;
    apply_reset();
    drive_str("begi", 1'b0);
    drive_char(8'h6e, 1'b1);
    checks++;
    if (result_a !== 1'b0 || depth_a !== 8'd0) begin
      fails++; $display("FAIL basic_after_n actual r=%b d=%0d expected r=0 d=0", result_a, depth_a);
    end
    drive_str(" end ", 1'b0);
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL basic_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL basic_b actual=%h expected=%h", ab, eb); end
    end
    checks++;
    if (result_a !== 1'b1 || depth_a !== 8'd0) begin
      fails++; $display("FAIL basic_final actual r=%b d=%0d expected r=1 d=0", result_a, depth_a);
    end
  endtask

  task automatic test_case_fold();
    obs_t ea, aa, eb, ab;
    apply_reset();
    drive_str("BeGiN begin enD ", 1'b0);
    checks++;
    if (result_a !== 1'b0 || depth_a !== 8'd1) begin
      fails++; $display("FAIL fold_mid actual r=%b d=%0d expected r=0 d=1", result_a, depth_a);
    end
    drive_str("end ", 1'b0);
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL fold_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL fold_b actual=%h expected=%h", ab, eb); end
    end
    checks++;
    if (result_a !== 1'b1 || depth_a !== 8'd0) begin
      fails++; $display("FAIL fold_final actual r=%b d=%0d expected r=1 d=0", result_a, depth_a);
    end
  endtask

  task automatic test_underflow();
    obs_t ea, aa, eb, ab;
    apply_reset();
    drive_str("end ", 1'b0);
    checks++;
    if (err_underflow_a !== 1'b1 || depth_a !== 8'd0 || result_a !== 1'b0) begin
      fails++; $display("FAIL underflow_first actual u=%b d=%0d r=%b expected u=1 d=0 r=0",
                        err_underflow_a, depth_a, result_a);
    end
    drive_str("begin ", 1'b0);
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL underflow_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL underflow_b actual=%h expected=%h", ab, eb); end
    end
    checks++;
    if (result_a !== 1'b0 || err_underflow_a !== 1'b1) begin
      fails++; $display("FAIL underflow_sticky actual r=%b u=%b expected r=0 u=1", result_a, err_underflow_a);
    end
  endtask

  task automatic test_overflow();
    obs_t ea, aa, eb, ab;
    apply_reset();
    for (int i = 0; i < 4; i++) drive_str("begin ", 1'b0);
    checks++;
    if (depth_b !== 2'd3 || err_overflow_b !== 1'b1 || depth_a !== 8'd4 || err_overflow_a !== 1'b0) begin
      fails++; $display("FAIL overflow_sat actual db=%0d ob=%b da=%0d oa=%b expected db=3 ob=1 da=4 oa=0",
                        depth_b, err_overflow_b, depth_a, err_overflow_a);
    end
    for (int i = 0; i < 3; i++) drive_str("end ", 1'b0);
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL overflow_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL overflow_b actual=%h expected=%h", ab, eb); end
    end
    checks++;
    if (depth_b !== 2'd0 || err_overflow_b !== 1'b0 || result_b !== 1'b1) begin
      fails++; $display("FAIL overflow_clear actual d=%0d o=%b r=%b expected d=0 o=0 r=1",
                        depth_b, err_overflow_b, result_b);
    end
  endtask

  task automatic test_non_keywords();
    obs_t ea, aa, eb, ab;
    apply_reset();
    drive_str("beginx endd be9in  BEGIN! e-nd ", 1'b0);
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL nonkw_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL nonkw_b actual=%h expected=%h", ab, eb); end
    end
    checks++;
    if ({result_a, depth_a, err_overflow_a, err_underflow_a} !== 11'b1_00000000_0_0) begin
      fails++; $display("FAIL nonkw_final actual r=%b d=%0d o=%b u=%b expected r=1 d=0 o=0 u=0",
                        result_a, depth_a, err_overflow_a, err_underflow_a);
    end
  endtask

  task automatic test_midword_reset();
    obs_t ea, aa, eb, ab;
    apply_reset();
    drive_str("begin be", 1'b1);
    apply_reset();
    checks++;
    if ({result_a, depth_a, err_overflow_a, err_underflow_a} !== 11'b1_00000000_0_0) begin
      fails++; $display("FAIL midword_reset actual r=%b d=%0d o=%b u=%b expected r=1 d=0 o=0 u=0",
                        result_a, depth_a, err_overflow_a, err_underflow_a);
    end
    drive_str("gin end ", 1'b1);
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL midword_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL midword_b actual=%h expected=%h", ab, eb); end
    end
    checks++;
    if (err_underflow_a !== 1'b1 || depth_a !== 8'd0) begin
      fails++; $display("FAIL midword_discard actual u=%b d=%0d expected u=1 d=0", err_underflow_a, depth_a);
    end
  endtask

  task automatic test_random_stream();
    obs_t  ea, aa, eb, ab;
    string words[10] = '{"begin", "end", "BEGIN", "End", "beg", "ends", "x", "be9in", "eNd", "bEgIn"};
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      drive_str(words[$urandom_range(0, 9)], 1'b1);
      if ($urandom_range(0, 7) != 0) drive_char(8'h20, 1'b1);
      if ($urandom_range(0, 3) == 0) drive_char(8'h20, 1'b1);
    end
    drive_char(8'h20, 1'b1);
    while (exp_a.size() != 0) begin
      ea = exp_a.pop_front(); aa = act_a.pop_front();
      eb = exp_b.pop_front(); ab = act_b.pop_front();
      checks += 2;
      if (aa !== ea) begin fails++; $display("FAIL random_a actual=%h expected=%h", aa, ea); end
      if (ab !== eb) begin fails++; $display("FAIL random_b actual=%h expected=%h", ab, eb); end
    end
  endtask

  initial begin
    reset       = 1'b0;
    in          = 8'h00;
    in_valid    = 1'b0;
    m_max[0]    = 255;
    m_max[1]    = 3;
    m_sticky[0] = 1'b1;
    m_sticky[1] = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_case_fold();
    test_underflow();
    test_overflow();
    test_non_keywords();
    test_midword_reset();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
